// File: rtl/mul_flag_unit.sv
// mul_flag_unit: iterative shift-add MUL/MLA unit for the execute stage.
// Produces the 32-bit product (plus accumulate for MLA) and the NZCV vector
// with a one-cycle write strobe for the downstream status register.
// Optional build macro MUL_EARLY_TERM_EN: leave RUN as soon as the remaining
// multiplier bits are all zero; without it every operation takes WIDTH
// iterations and the early-exit comparator is not built.
module mul_flag_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] acc,
    input  logic             accumulate,
    input  logic             set_flags,
    input  logic [3:0]       flags_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       stat_bits,
    output logic             stat_wr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0] count;
    logic             s_reg;
    logic [1:0]       snap_cv;

    logic             load;
    logic             step;
    logic             finish;
    logic             last_iter;

    // N and Z are recomputed from the result; only C and V are carried through
    logic             unused_flags;
    assign unused_flags = ^flags_in[3:2];

    // Decide whether the iteration happening this cycle is the final one
    always_comb begin
`ifdef MUL_EARLY_TERM_EN
        last_iter = (count == LAST_CNT) || (mplier[WIDTH-1:1] == '0);
`else
        last_iter = (count == LAST_CNT);
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush wins over everything, including start in IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start && !flush) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else if (last_iter) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output/control decode from the current state
    always_comb begin
        busy   = 1'b0;
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        unique case (state)
            ST_IDLE: begin
                load = start && !flush;
            end
            ST_RUN: begin
                busy = 1'b1;
                step = !flush;
            end
            ST_FIN: begin
                busy   = 1'b1;
                finish = !flush;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Operand capture and one shift-add iteration per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc_reg <= '0;
            count   <= '0;
            s_reg   <= 1'b0;
            snap_cv <= '0;
        end else if (load) begin
            mcand   <= op_a;
            mplier  <= op_b;
            acc_reg <= accumulate ? acc : '0;
            count   <= '0;
            s_reg   <= set_flags;
            snap_cv <= flags_in[1:0];
        end else if (step) begin
            if (mplier[0]) begin
                acc_reg <= acc_reg + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end

    // Registered result, done pulse and status-register write; stat_bits
    // only moves on a flag-setting completion so it holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            stat_wr   <= 1'b0;
            result    <= '0;
            stat_bits <= '0;
        end else begin
            done    <= finish;
            stat_wr <= finish && s_reg;
            if (finish) begin
                result <= acc_reg;
            end
            if (finish && s_reg) begin
                stat_bits <= {acc_reg[WIDTH-1], (acc_reg == '0), snap_cv};
            end
        end
    end

endmodule

// File: tb/tb_mul_flag_unit.sv
// Self-checking bench for mul_flag_unit: expected results are pushed to a
// scoreboard when an operation is driven and compared when done pulses.
module tb_mul_flag_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] acc;
    logic        accumulate;
    logic        set_flags;
    logic [3:0]  flags_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  stat_bits;
    logic        stat_wr;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  stat;
        logic        wr;
        int          done_cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         tests = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [3:0] model_stat = 4'b0000;

    mul_flag_unit #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .op_a      (op_a),
        .op_b      (op_b),
        .acc       (acc),
        .accumulate(accumulate),
        .set_flags (set_flags),
        .flags_in  (flags_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .stat_bits (stat_bits),
        .stat_wr   (stat_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Cycles from the start-sampling edge until done is visible
    function automatic int exp_lat(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
        int hi;
        hi = 0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) hi = i;
        end
        return hi + 2;
`else
        return 33;
`endif
    endfunction

    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                            input logic accm, input logic s, input logic [3:0] fl,
                            input logic push);
        exp_t        e;
        logic [63:0] full;
        logic [31:0] r;
        op_a       = a;
        op_b       = b;
        acc        = c;
        accumulate = accm;
        set_flags  = s;
        flags_in   = fl;
        flush      = 1'b0;
        start      = 1'b1;
        if (push) begin
            full = {32'd0, a} * {32'd0, b} + (accm ? {32'd0, c} : 64'd0);
            r    = full[31:0];
            if (s) model_stat = {r[31], (r == 32'd0), fl[1:0]};
            e.result   = r;
            e.stat     = model_stat;
            e.wr       = s;
            e.done_cyc = cyc + 1 + exp_lat(b);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        if (!done) check({tag, "_timeout"}, done, 1'b1);
    endtask

    // Scoreboard consumer: every done must match the oldest pending op
    always @(negedge clk) begin
        if (rst_n) begin
            if (stat_wr && !done) check("stat_wr_without_done", stat_wr, 1'b0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", done, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    check("result", result, mon_e.result);
                    check("stat_bits", stat_bits, mon_e.stat);
                    check("stat_wr", stat_wr, mon_e.wr);
                    check("latency", cyc, mon_e.done_cyc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, rc;
        logic        rm, rs;
        logic [3:0]  rf;

        rst_n      = 1'b0;
        start      = 1'b0;
        flush      = 1'b0;
        op_a       = '0;
        op_b       = '0;
        acc        = '0;
        accumulate = 1'b0;
        set_flags  = 1'b0;
        flags_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 32'd0);
        check("rst_stat_bits", stat_bits, 4'd0);
        check("rst_stat_wr", stat_wr, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // MUL, S=1
        drive_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 4'b0011, 1'b1);
        check("busy_after_start", busy, 1'b1);
        wait_done("mul");
        @(posedge clk); #1;

        // MLA wrapping to a negative result
        drive_op(32'hFFFF_FFFF, 32'd2, 32'd1, 1'b1, 1'b1, 4'b0100, 1'b1);
        wait_done("mla_neg");
        @(posedge clk); #1;

        // Zero product with S=0: flags must hold
        drive_op(32'h1234_5678, 32'd0, 32'd0, 1'b0, 1'b0, 4'b1111, 1'b1);
        wait_done("zero_s0");
        @(posedge clk); #1;

        // Zero product with S=1: Z set, N/Z from result, C/V from snapshot
        drive_op(32'h1234_5678, 32'd0, 32'd0, 1'b0, 1'b1, 4'b1010, 1'b1);
        wait_done("zero_s1");
        @(posedge clk); #1;

        // Short multiplier
        drive_op(32'd5, 32'd3, 32'd0, 1'b0, 1'b1, 4'b0000, 1'b1);
        wait_done("short");
        @(posedge clk); #1;

        // Flush after five iterations: no done, result untouched
        drive_op(32'd9, 32'h8000_0001, 32'd0, 1'b0, 1'b1, 4'b0001, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", busy, 1'b0);
        check("flush_result_kept", result, 32'd15);
        repeat (40) @(posedge clk);
        #1;

        // Flush beats start in IDLE
        op_a  = 32'd4;
        op_b  = 32'd4;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush_prio_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Start during RUN is ignored, then back-to-back start in the done cycle
        drive_op(32'd1000, 32'h8000_0003, 32'd0, 1'b0, 1'b1, 4'b0010, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        op_a       = 32'd77;
        op_b       = 32'd5;
        acc        = 32'd99;
        accumulate = 1'b1;
        set_flags  = 1'b0;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_start");
        drive_op(32'd22, 32'd33, 32'd100, 1'b1, 1'b1, 4'b0011, 1'b1);
        check("b2b_busy", busy, 1'b1);
        wait_done("b2b");
        @(posedge clk); #1;

        // Asynchronous reset in the middle of RUN
        drive_op(32'd3, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 4'b0000, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_result", result, 32'd0);
        check("arst_stat_bits", stat_bits, 4'd0);
        model_stat = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Highest multiplier bit only
        drive_op(32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 4'b0001, 1'b1);
        wait_done("msb");
        @(posedge clk); #1;

        // Random operations
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            rc = $urandom;
            rm = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            rf = 4'($urandom_range(0, 15));
            drive_op(ra, rb, rc, rm, rs, rf, 1'b1);
            wait_done("rand");
            @(posedge clk); #1;
        end

        repeat (20) @(posedge clk);
        #1;
        check("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
